// File: rtl/k1_mul_pkg.sv
// Shared constants and types for the K1 sequential multiplier.
package k1_mul_pkg;

    localparam int MUL_W     = 16;
    localparam int PROD_W    = 32;
    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/adder16bit.sv
// 16-bit ripple-carry adder built from full-adder cells; purely combinational.
module adder16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit; the carry ripples from bit 0 to bit 15.
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[16];

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier, one partial product
// per clock, using a single adder16bit instance for all arithmetic.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and low while rst is high);
// out_valid is high only in DONE and product is held stable there until
// out_ready is seen. in_ready and out_valid are never high together, so an
// operand accept can never coincide with a product handshake.
module mul16_seq
    import k1_mul_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_W-1:0]    a,
    input  logic [MUL_W-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   product,
    output logic                busy,
    output mul_state_t          state_dbg
);

    mul_state_t       state;
    mul_state_t       state_next;

    logic [MUL_W-1:0] mcand;
    logic [MUL_W-1:0] hi;
    logic [MUL_W-1:0] lo;
    logic [3:0]       cnt;

    logic             load;
    logic             bypass;
    logic             step;

    logic [MUL_W-1:0] addend;
    logic [MUL_W-1:0] sum;
    logic             cout;
    logic [32:0]      shift_src;

    // Partial product: add the multiplicand into hi only when the current
    // multiplier bit (lo[0]) is set.
    assign addend = lo[0] ? mcand : '0;

    adder16bit u_add (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The full 17-bit sum is kept so the carry lands in hi[15] after the shift.
    assign shift_src = {cout, sum, lo};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake outputs and datapath controls.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        bypass     = 1'b0;
        step       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            MUL_IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    load = 1'b1;
                    if (ZERO_BYPASS && ((a == '0) || (b == '0))) begin
                        bypass     = 1'b1;
                        state_next = MUL_DONE;
                    end else begin
                        state_next = MUL_RUN;
                    end
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 4'(MUL_STEPS - 1)) begin
                    state_next = MUL_DONE;
                end
            end
            MUL_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = MUL_IDLE;
                end
            end
            default: begin
                state_next = MUL_IDLE;
            end
        endcase
    end

    // Operand load and shift-and-add step; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= a;
            hi    <= '0;
            lo    <= bypass ? '0 : b;
            cnt   <= '0;
        end else if (step) begin
            hi    <= shift_src[32:17];
            lo    <= shift_src[16:1];
            cnt   <= cnt + 4'd1;
        end
    end

    assign product   = {hi, lo};
    assign state_dbg = state;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed cases, then a random sweep
// against a plain-arithmetic reference (a*b and the expected latency).
module tb_mul16_seq;
    import k1_mul_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;
    mul_state_t  state_dbg;

    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] product2;
    logic        busy2;
    mul_state_t  state_dbg2;

    logic [31:0] exp_q[$];
    int          total;
    int          bad;

    mul16_seq #(.ZERO_BYPASS(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    mul16_seq #(.ZERO_BYPASS(1'b0)) dut_nb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .product   (product2),
        .busy      (busy2),
        .state_dbg (state_dbg2)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_valid2 = 1'b1;
        a         = 16'h0005;
        b         = 16'h0007;
        out_ready = 1'b0;
        out_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(MUL_IDLE));
        check("rst_nb_product", product2, 32'd0);
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        rst       = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("post_rst_idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    // One full transaction on the ZERO_BYPASS=1 instance, with 'stall'
    // cycles of out_ready low once the product is presented.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input int stall);
        int n;
        int exp_lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a         = ta;
        b         = tbv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(32'(ta) * 32'(tbv));
        exp_lat = ((ta == 16'd0) || (tbv == 16'd0)) ? 1 : 17;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            check("run_no_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n + 1), 32'(exp_lat));
        for (int i = 0; i < stall; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_product", product, exp_q[0]);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom);
            a        = 16'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_busy", 32'(busy), 32'd1);
        check("product", product, exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        check("pulse_end_out_valid", 32'(out_valid), 32'd0);
        check("back_idle_in_ready", 32'(in_ready), 32'd1);
        check("back_idle_busy", 32'(busy), 32'd0);
    endtask

    // Directed steps followed by the random sweep.
    initial begin
        int  n;
        bit  seen;
        logic [15:0] ra;
        logic [15:0] rb;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        a          = '0;
        b          = '0;

        do_reset();

        run_op(16'd3, 16'd5, 0);
        run_op(16'hFFFF, 16'hFFFF, 0);
        run_op(16'h0000, 16'h1234, 0);
        run_op(16'h1234, 16'h0000, 2);
        run_op(16'h1234, 16'h0100, 5);
        run_op(16'h0001, 16'hFFFF, 1);
        run_op(16'h8000, 16'h8000, 0);

        // Zero operand without the bypass still takes the full 17 cycles.
        a         = 16'h0000;
        b         = 16'h1234;
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("nb_latency", 32'(n + 1), 32'd17);
        check("nb_product", product2, 32'd0);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("nb_pulse_end", 32'(out_valid2), 32'd0);
        check("nb_in_ready", 32'(in_ready2), 32'd1);

        // Reset in the middle of RUN aborts the operation.
        a        = 16'hABCD;
        b        = 16'h00FF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_in_ready", 32'(in_ready), 32'd1);
        check("midrun_product", product, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrun_no_output", 32'(seen), 32'd0);
        run_op(16'd7, 16'd6, 0);

        // Random sweep with occasional zero operands and output stalls.
        for (int k = 0; k < 1000; k++) begin
            ra = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
